rv_mc_ctrl: RTL and testbench

//  Multi-cycle main controller for the RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB per instruction.

---
 rtl/rv_mc_ctrl.sv | 177 +++++++++++++++++
 tb/tb_rv_mc_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// shared memory-port handshake, memory-timeout fault and retired-instruction counter.
module rv_mc_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       opcode_i,
    input  logic             branch_taken_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       alu_op_o,
    output logic             alu_src_o,
    output logic             branch_o,
    output logic             rd_we_o,
    output logic             alu_dst_o,
    output logic             instr_done_o,
    output logic [CNT_W-1:0] instret_o,
    output logic             fault_o,
    output logic [2:0]       state_o
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Class NONE doubles as the cleared value and the illegal-opcode marker.
    localparam logic [2:0] C_NONE   = 3'd0;
    localparam logic [2:0] C_R      = 3'd1;
    localparam logic [2:0] C_I      = 3'd2;
    localparam logic [2:0] C_LOAD   = 3'd3;
    localparam logic [2:0] C_STORE  = 3'd4;
    localparam logic [2:0] C_BRANCH = 3'd5;

    localparam bit TO_EN = (MEM_TIMEOUT > 0);
    localparam int TW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    function automatic logic [2:0] classify(input logic [6:0] op);
        case (op)
            OP_R:      classify = C_R;
            OP_I:      classify = C_I;
            OP_LOAD:   classify = C_LOAD;
            OP_STORE:  classify = C_STORE;
            OP_BRANCH: classify = C_BRANCH;
            default:   classify = C_NONE;
        endcase
    endfunction

    logic [2:0]       state_q, state_d;
    logic [2:0]       cls_q;
    logic [TW-1:0]    tcnt_q;
    logic [CNT_W-1:0] instret_q;
    logic             mem_phase;
    logic             timeout_hit;

    assign mem_phase   = (state_q == S_FETCH) || (state_q == S_MEM);
    // An ack in the final permitted cycle still wins over the timeout.
    assign timeout_hit = TO_EN && mem_phase && !mem_ack_i && (tcnt_q == TW'(MEM_TIMEOUT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            cls_q     <= C_NONE;
            tcnt_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                cls_q <= classify(opcode_i);
            if (state_d != state_q)
                tcnt_q <= '0;
            else if (TO_EN && mem_phase && !mem_ack_i)
                tcnt_q <= tcnt_q + TW'(1);
            if (instr_done_o)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ack_i)
                    state_d = S_DECODE;
                else if (timeout_hit)
                    state_d = S_FAULT;
            end
            S_DECODE: state_d = (classify(opcode_i) == C_NONE) ? S_FAULT : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    C_R, C_I:         state_d = S_WB;
                    C_LOAD, C_STORE:  state_d = S_MEM;
                    C_BRANCH:         state_d = S_FETCH;
                    default:          state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                if (mem_ack_i)
                    state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
                else if (timeout_hit)
                    state_d = S_FAULT;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FAULT;
        endcase
    end

    // Strobes are forced low for the whole reset cycle, whatever the state register holds.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        alu_op_o     = 2'b00;
        alu_src_o    = 1'b0;
        branch_o     = 1'b0;
        rd_we_o      = 1'b0;
        alu_dst_o    = 1'b0;
        instr_done_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_FETCH: begin
                    mem_req_o = 1'b1;
                    ir_we_o   = mem_ack_i;
                    pc_we_o   = mem_ack_i;
                end
                S_EXEC: begin
                    case (cls_q)
                        C_R: alu_op_o = 2'b10;
                        C_I: begin
                            alu_op_o  = 2'b10;
                            alu_src_o = 1'b1;
                        end
                        C_LOAD, C_STORE: alu_src_o = 1'b1;
                        C_BRANCH: begin
                            alu_op_o     = 2'b01;
                            branch_o     = 1'b1;
                            pc_we_o      = branch_taken_i;
                            instr_done_o = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req_o    = 1'b1;
                    mem_we_o     = (cls_q == C_STORE);
                    alu_src_o    = 1'b1;
                    instr_done_o = mem_ack_i && (cls_q == C_STORE);
                end
                S_WB: begin
                    rd_we_o      = 1'b1;
                    alu_dst_o    = (cls_q == C_LOAD);
                    instr_done_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instret_o = instret_q;
    assign fault_o   = (state_q == S_FAULT);
    assign state_o   = state_q;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Bench for rv_mc_ctrl: per-instruction expected cycle traces are generated from
// the instruction-class rules and compared against the DUT every cycle.
module tb_rv_mc_ctrl;

    localparam int TO = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_i, branch_taken_i, mem_ack_i;
    logic [6:0]    opcode_i;
    logic          mem_req_o, mem_we_o, ir_we_o, pc_we_o, alu_src_o, branch_o;
    logic          rd_we_o, alu_dst_o, instr_done_o, fault_o;
    logic [1:0]    alu_op_o;
    logic [CW-1:0] instret_o;
    logic [2:0]    state_o;
    logic [14:0]   obs;

    int n_assert = 0;
    int n_fail   = 0;
    int model_cnt = 0;
    bit flt;

    always #5 clk = ~clk;

    rv_mc_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .branch_taken_i(branch_taken_i),
        .mem_ack_i(mem_ack_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .ir_we_o(ir_we_o),
        .pc_we_o(pc_we_o), .alu_op_o(alu_op_o), .alu_src_o(alu_src_o), .branch_o(branch_o),
        .rd_we_o(rd_we_o), .alu_dst_o(alu_dst_o), .instr_done_o(instr_done_o),
        .instret_o(instret_o), .fault_o(fault_o), .state_o(state_o)
    );

    assign obs = {state_o, fault_o, mem_req_o, mem_we_o, ir_we_o, pc_we_o, alu_op_o,
                  alu_src_o, branch_o, rd_we_o, alu_dst_o, instr_done_o};

    // rwip = {req, we, ir_we, pc_we}; sbrd = {alu_src, branch, rd_we, alu_dst}
    function automatic logic [14:0] ev(input logic [2:0] st, input logic [3:0] rwip,
                                       input logic [1:0] op, input logic [3:0] sbrd,
                                       input logic done);
        return {st, (st == 3'd7), rwip, op, sbrd, done};
    endfunction

    task automatic cyc(input string tag, input logic ack, input logic [14:0] e);
        mem_ack_i = ack;
        #1;
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: outputs got %h want %h", tag, obs, e);
        end
        n_assert++;
        assert (instret_o === CW'(model_cnt)) else begin
            n_fail++;
            $error("FAIL %s_instret: got %0d want %0d", tag, instret_o, CW'(model_cnt));
        end
        @(posedge clk);
        #1;
        if (e[0]) model_cnt++;
    endtask

    task automatic do_reset(input string tag);
        rst_i = 1'b1;
        mem_ack_i = 1'($urandom);
        #1;
        n_assert++;
        assert (obs[10:0] === 11'd0) else begin
            n_fail++;
            $error("FAIL %s_strobes: got %h want 000", tag, obs[10:0]);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_cnt = 0;
    endtask

    task automatic fault_run(input int n);
        for (int k = 0; k < n; k++)
            cyc("fault", 1'($urandom), ev(3'd7, 4'b0000, 2'b00, 4'b0000, 1'b0));
    endtask

    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input logic taken, input bit rst_at_mem, output bit faulted);
        logic st;
        faulted = 1'b0;
        branch_taken_i = taken;
        opcode_i = 7'($urandom);
        for (int i = 0; i < fw; i++) begin
            cyc("fetch_wait", 1'b0, ev(3'd0, 4'b1000, 2'b00, 4'b0000, 1'b0));
            if (i == TO) begin
                fault_run(3);
                faulted = 1'b1;
                return;
            end
        end
        cyc("fetch_ack", 1'b1, ev(3'd0, 4'b1011, 2'b00, 4'b0000, 1'b0));
        opcode_i = op;
        cyc("decode", 1'($urandom), ev(3'd1, 4'b0000, 2'b00, 4'b0000, 1'b0));
        case (op)
            7'b0110011: begin
                cyc("exec_r", 1'($urandom), ev(3'd2, 4'b0000, 2'b10, 4'b0000, 1'b0));
                cyc("wb_r", 1'($urandom), ev(3'd4, 4'b0000, 2'b00, 4'b0010, 1'b1));
            end
            7'b0010011: begin
                cyc("exec_i", 1'($urandom), ev(3'd2, 4'b0000, 2'b10, 4'b1000, 1'b0));
                cyc("wb_i", 1'($urandom), ev(3'd4, 4'b0000, 2'b00, 4'b0010, 1'b1));
            end
            7'b0000011, 7'b0100011: begin
                st = (op == 7'b0100011);
                cyc("exec_ldst", 1'($urandom), ev(3'd2, 4'b0000, 2'b00, 4'b1000, 1'b0));
                if (rst_at_mem) begin
                    do_reset("rst_in_mem");
                    return;
                end
                for (int i = 0; i < mw; i++) begin
                    cyc("mem_wait", 1'b0, ev(3'd3, {1'b1, st, 2'b00}, 2'b00, 4'b1000, 1'b0));
                    if (i == TO) begin
                        fault_run(3);
                        faulted = 1'b1;
                        return;
                    end
                end
                cyc("mem_ack", 1'b1, ev(3'd3, {1'b1, st, 2'b00}, 2'b00, 4'b1000, st));
                if (!st)
                    cyc("wb_load", 1'($urandom), ev(3'd4, 4'b0000, 2'b00, 4'b0011, 1'b1));
            end
            7'b1100011:
                cyc("exec_br", 1'($urandom), ev(3'd2, {3'b000, taken}, 2'b01, 4'b0100, 1'b1));
            default: begin
                fault_run(20);
                faulted = 1'b1;
            end
        endcase
    endtask

    initial begin
        logic [6:0] legal [5];
        logic [6:0] op;
        int fw, mw;
        legal[0] = 7'b0110011; legal[1] = 7'b0010011; legal[2] = 7'b0000011;
        legal[3] = 7'b0100011; legal[4] = 7'b1100011;
        rst_i = 1'b1; opcode_i = 7'd0; mem_ack_i = 1'b0; branch_taken_i = 1'b0;
        @(posedge clk);
        #1;
        do_reset("init");

        run_instr(7'b0110011, 0, 0, 1'b0, 1'b0, flt);
        run_instr(7'b0000011, 0, 2, 1'b0, 1'b0, flt);
        run_instr(7'b0100011, 1, 0, 1'b0, 1'b0, flt);
        run_instr(7'b1100011, 0, 0, 1'b1, 1'b0, flt);
        run_instr(7'b1100011, 0, 0, 1'b0, 1'b0, flt);
        run_instr(7'b0010011, 2, 0, 1'b0, 1'b0, flt);
        run_instr(7'b1111111, 0, 0, 1'b0, 1'b0, flt);
        do_reset("after_illegal");
        run_instr(7'b0110011, 4, 0, 1'b0, 1'b0, flt);
        do_reset("after_fetch_to");
        run_instr(7'b0110011, 3, 0, 1'b0, 1'b0, flt);
        run_instr(7'b0000011, 0, 4, 1'b0, 1'b0, flt);
        do_reset("after_mem_to");
        run_instr(7'b0000011, 1, 0, 1'b0, 1'b1, flt);
        run_instr(7'b0110011, 0, 0, 1'b0, 1'b0, flt);
        for (int n = 0; n < 17; n++)
            run_instr(7'b0110011, 0, 0, 1'b0, 1'b0, flt);

        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 11) == 0) ? 7'($urandom) : legal[$urandom_range(0, 4)];
            fw = ($urandom_range(0, 15) == 0) ? 4 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 15) == 0) ? 4 : int'($urandom_range(0, 3));
            run_instr(op, fw, mw, 1'($urandom), 1'b0, flt);
            if (flt) do_reset("rand_recover");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
